// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: slice op codes and sequencer states.
package alu_pkg;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_NOTA  = 3'b010;
   localparam logic [2:0] OP_NOTB  = 3'b011;
   localparam logic [2:0] OP_OR    = 3'b100;
   localparam logic [2:0] OP_ORNB  = 3'b101;
   localparam logic [2:0] OP_AND   = 3'b110;
   localparam logic [2:0] OP_ANDNB = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ALUslice.sv
// One-bit ALU slice: full adder with optional B inversion plus NOT/OR/AND functions.
module ALUslice (
   input  logic [2:0] c,
   input  logic       ai,
   input  logic       bi,
   input  logic       ci,
   output logic       co,
   output logic       f
);

   logic bx;

   // c[0] selects ~b for subtract and for every "~b" logic variant; ~a (010) has c[0]=0
   assign bx = c[0] ? ~bi : bi;
   assign co = (ai & bx) | (ai & ci) | (bx & ci);

   always_comb begin
      f = 1'b0;
      case (c[2:1])
         2'b00:   f = ai ^ bx ^ ci;
         2'b01:   f = c[0] ? bx : ~ai;
         2'b10:   f = ai | bx;
         default: f = ai & bx;
      endcase
   end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Sequencer that drives a single ALUslice LSB-first over WIDTH cycles to form a WIDTH-bit result.
module bit_serial_alu_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, r_sr, result_r;
   logic [2:0]       op_r;
   logic [CNT_W-1:0] cnt;
   logic             carry, cout_r;
   logic             slice_co, slice_f;
   logic             last_bit;

   ALUslice u_slice (
      .c  (op_r),
      .ai (a_sr[0]),
      .bi (b_sr[0]),
      .ci (carry),
      .co (slice_co),
      .f  (slice_f)
   );

   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last_bit) state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   // result/cout are captured on the final RUN edge so they are valid together with done
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         r_sr     <= '0;
         op_r     <= '0;
         cnt      <= '0;
         carry    <= 1'b0;
         result_r <= '0;
         cout_r   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  op_r  <= op;
                  cnt   <= '0;
                  carry <= (op == OP_SUB);
               end
            end
            S_RUN: begin
               r_sr  <= {slice_f, r_sr[WIDTH-1:1]};
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               carry <= slice_co;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  result_r <= {slice_f, r_sr[WIDTH-1:1]};
                  cout_r   <= (op_r[2:1] == 2'b00) & slice_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign result = result_r;
   assign cout   = cout_r;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench: transaction-level reference model compared every cycle, plus directed literals.
module tb_bit_serial_alu_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, cout;
   logic [W-1:0] result;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   bit_serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns {cout, result} straight from the arithmetic meaning of each op
   function automatic logic [W:0] ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] s;
      case (o)
         3'b000:  s = {1'b0, x} + {1'b0, y};
         3'b001:  s = {1'b0, x} + {1'b0, ~y} + 1;
         3'b010:  s = {1'b0, ~x};
         3'b011:  s = {1'b0, ~y};
         3'b100:  s = {1'b0, x | y};
         3'b101:  s = {1'b0, x | ~y};
         3'b110:  s = {1'b0, x & y};
         default: s = {1'b0, x & ~y};
      endcase
      return s;
   endfunction

   // Model: an accepted op keeps the unit busy for W+1 cycles, the last of which is done
   int           m_cnt = 0;
   logic [W-1:0] m_res = '0;
   logic         m_cout = 1'b0;
   logic [W:0]   m_pend = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_cnt  = 0;
         m_res  = '0;
         m_cout = 1'b0;
      end else if (m_cnt == 0) begin
         if (start) begin
            m_cnt  = W + 1;
            m_pend = ref_op(op, a, b);
         end
      end else begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 1) {m_cout, m_res} = m_pend;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_busy",   {31'd0, busy}, {31'd0, (m_cnt != 0)});
         chk("cyc_done",   {31'd0, done}, {31'd0, (m_cnt == 1)});
         chk("cyc_result", {24'd0, result}, {24'd0, m_res});
         chk("cyc_cout",   {31'd0, cout}, {31'd0, m_cout});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Waits for done after the accept edge; returns cycle count, or 99 on timeout
   task automatic wait_done(output int k);
      k = 99;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] er, input logic ec);
      int k;
      chk({name, "_model"}, {23'd0, ref_op(o, x, y)}, {23'd0, ec, er});
      op = o; a = x; b = y; start = 1'b1;
      tick();
      start = 1'b0;
      a = ~x; b = ~y; op = ~o;
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(k);
      chk({name, "_latency"}, k, W);
      chk({name, "_result"}, {24'd0, result}, {24'd0, er});
      chk({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
      tick();
      chk({name, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      cmp_en = 1'b1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_result", {24'd0, result}, 32'd0);
      chk("reset_cout", {31'd0, cout}, 32'd0);
      tick();

      run_op("add",      3'b000, 8'h5A, 8'h3C, 8'h96, 1'b0);
      run_op("add_ovf",  3'b000, 8'hFF, 8'h01, 8'h00, 1'b1);
      run_op("sub_nb",   3'b001, 8'h10, 8'h01, 8'h0F, 1'b1);
      run_op("sub_brw",  3'b001, 8'h01, 8'h02, 8'hFF, 1'b0);
      run_op("nota",     3'b010, 8'hA5, 8'hF0, 8'h5A, 1'b0);
      run_op("notb",     3'b011, 8'hA5, 8'hF0, 8'h0F, 1'b0);
      run_op("or",       3'b100, 8'hA5, 8'hF0, 8'hF5, 1'b0);
      run_op("ornb",     3'b101, 8'hA5, 8'hF0, 8'hAF, 1'b0);
      run_op("and",      3'b110, 8'hA5, 8'hF0, 8'hA0, 1'b0);
      run_op("andnb",    3'b111, 8'hA5, 8'hF0, 8'h05, 1'b0);

      // start pulse in mid-RUN must be ignored and not queued
      op = 3'b000; a = 8'h5A; b = 8'h3C; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      op = 3'b001; a = 8'h11; b = 8'h22; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(k);
      chk("midrun_latency", k, W - 4);
      chk("midrun_result", {24'd0, result}, 32'h96);
      tick();
      chk("midrun_noqueue", {31'd0, busy}, 32'd0);
      tick();

      // start held high with operands changing every cycle
      start = 1'b1;
      for (int i = 0; i < 45; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         op = 3'($urandom);
         tick();
      end
      start = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      // reset during RUN bit 3 discards the op
      op = 3'b000; a = 8'h12; b = 8'h34; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_done", {31'd0, done}, 32'd0);
      chk("rstmid_result", {24'd0, result}, 32'd0);
      chk("rstmid_cout", {31'd0, cout}, 32'd0);
      k = 0;
      for (int i = 0; i < W + 3; i++) begin
         tick();
         if (done) k++;
      end
      chk("rstmid_no_done", k, 0);
      run_op("post_rst", 3'b001, 8'h80, 8'h7F, 8'h01, 1'b1);

      // random traffic with sporadic starts and resets
      for (int i = 0; i < 500; i++) begin
         start = ($urandom_range(0, 3) == 0);
         rst   = ($urandom_range(0, 79) == 0);
         a  = W'($urandom);
         b  = W'($urandom);
         op = 3'($urandom);
         tick();
      end
      rst = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
